// File: rtl/rst_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_if
//  Purpose  : Control/status bundle between a reset sequencer and its host.
//  Revision : 1.0 - initial release
// ============================================================================
interface rst_seq_if #(
    parameter int NUM_DOMAINS = 3,
    parameter int CNT_WIDTH   = 8
);
    logic [CNT_WIDTH-1:0]   dly_cfg;
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   seq_done;
    logic                   sw_rst_ack;
    logic                   busy;

    modport master (
        output dly_cfg,
        output sw_rst_req,
        input  dom_rst_n,
        input  seq_done,
        input  sw_rst_ack,
        input  busy
    );

    modport slave (
        input  dly_cfg,
        input  sw_rst_req,
        output dom_rst_n,
        output seq_done,
        output sw_rst_ack,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_ctrl
//  Purpose  : Ordered per-domain reset release with soft-reset handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    rst_seq_if.slave   bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0]     c_last_idx = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_ASSERT = 2'd3
    } state_t;

    state_t                 r_state,    w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt,      w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx,      w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_dom,      w_dom_nxt;
    logic                   r_done,     w_done_nxt;
    logic                   r_ack,      w_ack_nxt;
    logic                   r_busy,     w_busy_nxt;
    logic                   r_armed;
    logic [CNT_WIDTH-1:0]   w_deff;

    assign w_deff = (bus.dly_cfg == '0) ? c_one : bus.dly_cfg;

    // The first edge after reset deassertion only arms the sequencer, so
    // power-up and soft-reset releases both land HOLD-load + D edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dom   <= '0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
            r_done  <= w_done_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
        w_done_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_busy_nxt  = 1'b1;

        case (r_state)
            ST_HOLD: begin
                if (r_armed) begin
                    w_cnt_nxt   = w_deff;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == c_one) begin
                    w_dom_nxt[r_idx] = 1'b1;
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_cnt_nxt = w_deff;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.sw_rst_req) begin
                    w_dom_nxt   = '0;
                    w_cnt_nxt   = w_deff;
                    w_state_nxt = ST_ASSERT;
                end else begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (r_cnt == c_one) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    assign bus.dom_rst_n  = r_dom;
    assign bus.seq_done   = r_done;
    assign bus.sw_rst_ack = r_ack;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq_ctrl
//  Purpose  : Directed and randomized checks of rst_seq_ctrl against an
//             event-time reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;
    localparam int N  = 3;
    localparam int CW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rst_seq_if #(.NUM_DOMAINS(N), .CNT_WIDTH(CW)) bus ();

    rst_seq_ctrl #(.NUM_DOMAINS(N), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the edge number since reset release and the
    // edges at which the next events (HOLD load, releases, ACK) are due.
    int         m_n;
    int         m_hold_edge;
    int         m_next_rel;
    int         m_k;
    int         m_ack_edge;
    bit         m_releasing;
    bit         m_in_done;
    logic [N-1:0] e_dom;
    logic         e_done;
    logic         e_ack;
    logic         e_busy;

    function automatic int deff();
        return (bus.dly_cfg == 0) ? 1 : int'(bus.dly_cfg);
    endfunction

    task automatic model_reset();
        m_n         = -1;
        m_hold_edge = 1;
        m_next_rel  = -100;
        m_k         = 0;
        m_ack_edge  = -100;
        m_releasing = 1'b0;
        m_in_done   = 1'b0;
        e_dom       = '0;
        e_done      = 1'b0;
        e_ack       = 1'b0;
        e_busy      = 1'b1;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_n++;
            e_ack = (m_n == m_ack_edge);
            if (m_n == m_hold_edge) begin
                m_releasing = 1'b1;
                m_k         = 0;
                m_next_rel  = m_n + deff();
            end else if (m_releasing && m_n == m_next_rel) begin
                e_dom[m_k] = 1'b1;
                if (m_k == N - 1) begin
                    m_releasing = 1'b0;
                    m_in_done   = 1'b1;
                end else begin
                    m_k++;
                    m_next_rel = m_n + deff();
                end
            end else if (m_in_done) begin
                if (bus.sw_rst_req) begin
                    e_dom       = '0;
                    e_done      = 1'b0;
                    m_in_done   = 1'b0;
                    m_ack_edge  = m_n + deff();
                    m_hold_edge = m_n + deff() + 1;
                end else begin
                    e_done = 1'b1;
                end
            end
            e_busy = ~e_done;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, got, exp, m_n);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dom"},  32'(bus.dom_rst_n),  32'(e_dom));
        chk({tag, ".done"}, 32'(bus.seq_done),   32'(e_done));
        chk({tag, ".ack"},  32'(bus.sw_rst_ack), 32'(e_ack));
        chk({tag, ".busy"}, 32'(bus.busy),       32'(e_busy));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic do_reset(input int dly);
        @(negedge clk);
        rst_n           = 1'b0;
        bus.dly_cfg     = CW'(dly);
        bus.sw_rst_req  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all("rst");
        rst_n = 1'b1;
    endtask

    // Steps the sequence, checking model and the spec's absolute release
    // edges (relative to base) for each domain and SEQ_DONE.
    task automatic run_seq(input string tag, input int base, input int e0, input int e1,
                           input int e2, input int ed, input int len,
                           input int rq_from, input int rq_to,
                           input int chg_edge, input int chg_val);
        for (int i = 0; i < len; i++) begin
            bus.sw_rst_req = (m_n + 1 >= rq_from) && (m_n + 1 <= rq_to);
            if (m_n + 1 == chg_edge) bus.dly_cfg = CW'(chg_val);
            step(tag);
            if (m_n - base == e0 - 1) chk({tag, ".d0_low"},  32'(bus.dom_rst_n[0]), 0);
            if (m_n - base == e0)     chk({tag, ".d0_high"}, 32'(bus.dom_rst_n[0]), 1);
            if (m_n - base == e1 - 1) chk({tag, ".d1_low"},  32'(bus.dom_rst_n[1]), 0);
            if (m_n - base == e1)     chk({tag, ".d1_high"}, 32'(bus.dom_rst_n[1]), 1);
            if (m_n - base == e2 - 1) chk({tag, ".d2_low"},  32'(bus.dom_rst_n[2]), 0);
            if (m_n - base == e2)     chk({tag, ".d2_high"}, 32'(bus.dom_rst_n[2]), 1);
            if (m_n - base == ed - 1) chk({tag, ".done_low"},  32'(bus.seq_done), 0);
            if (m_n - base == ed)     chk({tag, ".done_high"}, 32'(bus.seq_done), 1);
            if (m_n - base == ed)     chk({tag, ".busy_low"},  32'(bus.busy), 0);
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".dom"},  32'(bus.dom_rst_n),  0);
        chk({tag, ".done"}, 32'(bus.seq_done),   0);
        chk({tag, ".ack"},  32'(bus.sw_rst_ack), 0);
        chk({tag, ".busy"}, 32'(bus.busy),       1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  e_req;
        bit  seen;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.dly_cfg    = CW'(4);
        bus.sw_rst_req = 1'b0;
        model_reset();

        // Power-up with D=4
        do_reset(4);
        run_seq("pwrup", 0, 5, 9, 13, 14, 18, -1, -2, -1, 0);

        // Soft reset from DONE, requester drops REQ on ACK
        bus.sw_rst_req = 1'b1;
        step("sreq");
        e_req = m_n;
        chk("sr.dom_low",  32'(bus.dom_rst_n), 0);
        chk("sr.done_low", 32'(bus.seq_done),  0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step("sr_wait");
            if (bus.sw_rst_ack) seen = 1'b1;
        end
        chk("sr.ack_seen", 32'(seen), 1);
        chk("sr.ack_lat",  32'(m_n - e_req), 4);
        bus.sw_rst_req = 1'b0;
        step("sr_ack_drop");
        chk("sr.ack_one_cycle", 32'(bus.sw_rst_ack), 0);
        run_seq("sr_rel", e_req, 9, 13, 17, 18, 24, -1, -2, -1, 0);

        // DLY_CFG = 0 behaves as 1
        do_reset(0);
        run_seq("dly0", 0, 2, 3, 4, 5, 10, -1, -2, -1, 0);

        // REQ held during edges 2..10 is ignored
        do_reset(4);
        run_seq("req_busy", 0, 5, 9, 13, 14, 20, 2, 10, -1, 0);

        // Asynchronous reset once domain 0 is out
        do_reset(4);
        run_seq("pre_async", 0, 5, 99, 99, 99, 6, -1, -2, -1, 0);
        chk("async.pre_dom", 32'(bus.dom_rst_n), 1);
        async_reset_pulse("async");
        run_seq("post_async", 0, 5, 9, 13, 14, 18, -1, -2, -1, 0);

        // DLY_CFG raised to 8 at edge 7
        do_reset(4);
        run_seq("dly_chg", 0, 5, 9, 17, 18, 22, -1, -2, 7, 8);

        // Randomized: delays, requests, mid-count delay changes, async resets
        do_reset(int'($urandom_range(0, 5)));
        for (int i = 0; i < 600; i++) begin
            bus.sw_rst_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) bus.dly_cfg = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 149) == 0) async_reset_pulse("rnd_async");
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
